// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU<->cache bus (A1/D1/C1): command codes,
// response code, address field widths, master state encoding and the
// per-command helper functions used by both bus ends.
package cpu_bus_pkg;

   localparam int TAG_W    = 8;
   localparam int SET_W    = 6;
   localparam int OFFSET_W = 4;

   typedef enum logic [2:0] {
      CMD_NOP        = 3'd0,
      CMD_READ8      = 3'd1,
      CMD_READ16     = 3'd2,
      CMD_READ32     = 3'd3,
      CMD_INVALIDATE = 3'd4,
      CMD_WRITE8     = 3'd5,
      CMD_WRITE16    = 3'd6,
      CMD_WRITE32    = 3'd7
   } cmd_e;

   // Code the cache places on C1 for every response beat
   localparam logic [2:0] C1_RESPONSE = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR1 = 3'd1,
      ST_ADDR2 = 3'd2,
      ST_TURN  = 3'd3,
      ST_WAIT  = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   // Number of response beats the cache returns for a command
   function automatic logic [1:0] beats_for(input logic [2:0] cmd);
      logic [1:0] n;
      case (cmd)
         CMD_READ32:  n = 2'd2;
         CMD_WRITE32: n = 2'd2;
         default:     n = 2'd1;
      endcase
      return n;
   endfunction

   function automatic logic is_read(input logic [2:0] cmd);
      logic r;
      case (cmd)
         CMD_READ8, CMD_READ16, CMD_READ32: r = 1'b1;
         default:                           r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_write(input logic [2:0] cmd);
      logic w;
      case (cmd)
         CMD_WRITE8, CMD_WRITE16, CMD_WRITE32: w = 1'b1;
         default:                              w = 1'b0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/bus_tristate_driver.sv
// Tri-state output stage for the shared data and command lines.
// Drive values and enables come from registers in the owning block, so the
// pads switch cleanly on clock edges. Also reused by the memory-side bus.
module bus_tristate_driver #(
   parameter int D_W = 16,
   parameter int C_W = 3
) (
   input  logic           d_oe,
   input  logic [D_W-1:0] d_out,
   input  logic           c_oe,
   input  logic [C_W-1:0] c_out,
   inout  wire  [D_W-1:0] d_bus,
   inout  wire  [C_W-1:0] c_bus
);

   assign d_bus = d_oe ? d_out : {D_W{1'bz}};
   assign c_bus = c_oe ? c_out : {C_W{1'bz}};

endmodule

// File: rtl/cpu_bus_master.sv
// CPU-side initiator for the A1/D1/C1 cache bus. Takes one request at a time,
// sends it as two address cycles, turns the bus around, collects the cache's
// response beats and reports completion with read data.
// Optional build macro CPU_BUS_TIMEOUT_EN bounds the response wait to
// TIMEOUT_CYCLES and flags an abort through resp_err.
module cpu_bus_master
   import cpu_bus_pkg::*;
#(
   parameter int ADDR_SIZE      = 18,
   parameter int ADDR1_BUS_SIZE = 14,
   parameter int DATA1_BUS_SIZE = 16,
   parameter int CTR1_BUS_SIZE  = 3,
   parameter int OFFSET_SIZE    = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [CTR1_BUS_SIZE-1:0]      req_cmd,
   input  logic [ADDR_SIZE-1:0]          req_addr,
   input  logic [2*DATA1_BUS_SIZE-1:0]   req_wdata,
   output logic                          resp_valid,
   output logic [2*DATA1_BUS_SIZE-1:0]   resp_rdata,
   output logic                          resp_err,
   output logic [ADDR1_BUS_SIZE-1:0]     A1,
   inout  wire  [DATA1_BUS_SIZE-1:0]     D1,
   inout  wire  [CTR1_BUS_SIZE-1:0]      C1,
   output logic [31:0]                   req_count
);

   localparam int DW = DATA1_BUS_SIZE;

   state_e                    state_r, state_next_s;
   logic [CTR1_BUS_SIZE-1:0]  cmd_r;
   logic [ADDR_SIZE-1:0]      addr_r;
   logic [2*DW-1:0]           wdata_r;
   logic [1:0]                beat_r, beat_next_s;
   logic [2*DW-1:0]           acc_r, acc_next_s;

   logic                      handshake_s;
   logic                      resp_hit_s;
   logic                      timeout_s;
   logic [DW-1:0]             d1_in_s;
   logic [CTR1_BUS_SIZE-1:0]  c1_in_s;

   logic [CTR1_BUS_SIZE-1:0]  cmd_nx_s;
   logic [ADDR_SIZE-1:0]      addr_nx_s;
   logic [2*DW-1:0]           wdata_nx_s;

   logic [ADDR1_BUS_SIZE-1:0] a1_r, a1_nx_s;
   logic                      c1_oe_r, c1_oe_nx_s;
   logic [CTR1_BUS_SIZE-1:0]  c1_out_r, c1_out_nx_s;
   logic                      d1_oe_r, d1_oe_nx_s;
   logic [DW-1:0]             d1_out_r, d1_out_nx_s;
   logic                      req_ready_r;
   logic                      resp_valid_r;
   logic                      resp_err_r, resp_err_nx_s;
   logic [2*DW-1:0]           resp_rdata_r, resp_rdata_nx_s;
   logic [31:0]               req_count_r;

   assign d1_in_s     = D1;
   assign c1_in_s     = C1;
   assign handshake_s = (state_r == ST_IDLE) && req_valid && (req_cmd != CMD_NOP);
   assign resp_hit_s  = (c1_in_s == C1_RESPONSE);

`ifdef CPU_BUS_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WAIT_W-1:0] wait_cnt_r;

   // Count cycles spent waiting for the response; restarts on every entry to WAIT
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_r <= '0;
      end else if (state_r == ST_TURN) begin
         wait_cnt_r <= '0;
      end else if (state_r == ST_WAIT) begin
         wait_cnt_r <= wait_cnt_r + 1'b1;
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end
`else
   logic unused_timeout_s;
   assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

   // Next state, beat counter and read-data assembly
   always_comb begin
      state_next_s = state_r;
      beat_next_s  = beat_r;
      acc_next_s   = acc_r;
      timeout_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (handshake_s) begin
               state_next_s = ST_ADDR1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ADDR1: state_next_s = ST_ADDR2;
         ST_ADDR2: state_next_s = ST_TURN;
         ST_TURN: begin
            state_next_s = ST_WAIT;
            beat_next_s  = 2'd0;
            acc_next_s   = '0;
         end
         ST_WAIT: begin
            if (resp_hit_s) begin
               if (!is_read(cmd_r)) begin
                  acc_next_s = acc_r;
               end else if (beat_r == 2'd0) begin
                  if (cmd_r == CMD_READ8) begin
                     acc_next_s[DW-1:0] = {{(DW-8){1'b0}}, d1_in_s[7:0]};
                  end else begin
                     acc_next_s[DW-1:0] = d1_in_s;
                  end
               end else begin
                  acc_next_s[2*DW-1:DW] = d1_in_s;
               end
               if ((beat_r + 2'd1) >= beats_for(cmd_r)) begin
                  state_next_s = ST_DONE;
               end else begin
                  beat_next_s  = beat_r + 2'd1;
                  state_next_s = ST_WAIT;
               end
            end else begin
`ifdef CPU_BUS_TIMEOUT_EN
               if (wait_cnt_r == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                  timeout_s    = 1'b1;
                  state_next_s = ST_DONE;
               end else begin
                  state_next_s = ST_WAIT;
               end
`else
               state_next_s = ST_WAIT;
`endif
            end
         end
         ST_DONE: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Bus drive values for the upcoming state, so pads are registered and aligned with state
   always_comb begin
      cmd_nx_s    = handshake_s ? req_cmd   : cmd_r;
      addr_nx_s   = handshake_s ? req_addr  : addr_r;
      wdata_nx_s  = handshake_s ? req_wdata : wdata_r;
      a1_nx_s     = a1_r;
      c1_oe_nx_s  = 1'b1;
      c1_out_nx_s = CMD_NOP;
      d1_oe_nx_s  = 1'b0;
      d1_out_nx_s = '0;
      case (state_next_s)
         ST_IDLE: c1_oe_nx_s = 1'b1;
         ST_ADDR1: begin
            a1_nx_s     = addr_nx_s[ADDR_SIZE-1:OFFSET_SIZE];
            c1_out_nx_s = cmd_nx_s;
            if (is_write(cmd_nx_s)) begin
               d1_oe_nx_s  = 1'b1;
               d1_out_nx_s = wdata_nx_s[DW-1:0];
            end else begin
               d1_oe_nx_s  = 1'b0;
            end
         end
         ST_ADDR2: begin
            a1_nx_s     = {{(ADDR1_BUS_SIZE-OFFSET_SIZE){1'b0}}, addr_nx_s[OFFSET_SIZE-1:0]};
            c1_out_nx_s = cmd_nx_s;
            if (cmd_nx_s == CMD_WRITE32) begin
               d1_oe_nx_s  = 1'b1;
               d1_out_nx_s = wdata_nx_s[2*DW-1:DW];
            end else if (is_write(cmd_nx_s)) begin
               d1_oe_nx_s  = 1'b1;
               d1_out_nx_s = wdata_nx_s[DW-1:0];
            end else begin
               d1_oe_nx_s  = 1'b0;
            end
         end
         ST_TURN, ST_WAIT: c1_oe_nx_s = 1'b0;
         ST_DONE: c1_out_nx_s = CMD_NOP;
         default: c1_oe_nx_s = 1'b1;
      endcase

      if (state_next_s == ST_DONE) begin
         resp_err_nx_s = timeout_s;
         if (timeout_s || !is_read(cmd_r)) begin
            resp_rdata_nx_s = '0;
         end else begin
            resp_rdata_nx_s = acc_next_s;
         end
      end else begin
         resp_err_nx_s   = 1'b0;
         resp_rdata_nx_s = resp_rdata_r;
      end
   end

   // State, transaction latches and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         cmd_r        <= CMD_NOP;
         addr_r       <= '0;
         wdata_r      <= '0;
         beat_r       <= 2'd0;
         acc_r        <= '0;
         a1_r         <= '0;
         c1_oe_r      <= 1'b1;
         c1_out_r     <= CMD_NOP;
         d1_oe_r      <= 1'b0;
         d1_out_r     <= '0;
         req_ready_r  <= 1'b1;
         resp_valid_r <= 1'b0;
         resp_err_r   <= 1'b0;
         resp_rdata_r <= '0;
         req_count_r  <= 32'd0;
      end else begin
         state_r      <= state_next_s;
         cmd_r        <= cmd_nx_s;
         addr_r       <= addr_nx_s;
         wdata_r      <= wdata_nx_s;
         beat_r       <= beat_next_s;
         acc_r        <= acc_next_s;
         a1_r         <= a1_nx_s;
         c1_oe_r      <= c1_oe_nx_s;
         c1_out_r     <= c1_out_nx_s;
         d1_oe_r      <= d1_oe_nx_s;
         d1_out_r     <= d1_out_nx_s;
         req_ready_r  <= (state_next_s == ST_IDLE);
         resp_valid_r <= (state_next_s == ST_DONE);
         resp_err_r   <= resp_err_nx_s;
         resp_rdata_r <= resp_rdata_nx_s;
         req_count_r  <= handshake_s ? (req_count_r + 32'd1) : req_count_r;
      end
   end

   assign A1         = a1_r;
   assign req_ready  = req_ready_r;
   assign resp_valid = resp_valid_r;
   assign resp_err   = resp_err_r;
   assign resp_rdata = resp_rdata_r;
   assign req_count  = req_count_r;

   bus_tristate_driver #(
      .D_W (DATA1_BUS_SIZE),
      .C_W (CTR1_BUS_SIZE)
   ) u_drv (
      .d_oe  (d1_oe_r),
      .d_out (d1_out_r),
      .c_oe  (c1_oe_r),
      .c_out (c1_out_r),
      .d_bus (D1),
      .c_bus (C1)
   );

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master: the bench plays the cache on D1/C1.
// A released line is checked by driving a known pattern from the bench and
// reading it back unchanged, which fails if the master drives the line too.
module tb_cpu_bus_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_cmd;
   logic [17:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [13:0] A1;
   logic [31:0] req_count;
   wire  [15:0] D1;
   wire  [2:0]  C1;

   logic        tb_d1_oe;
   logic [15:0] tb_d1;
   logic        tb_c1_oe;
   logic [2:0]  tb_c1;

   int checks = 0;
   int passes = 0;

   assign D1 = tb_d1_oe ? tb_d1 : 16'bz;
   assign C1 = tb_c1_oe ? tb_c1 : 3'bz;

   always #5 clk = ~clk;

   cpu_bus_master #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .A1(A1), .D1(D1), .C1(C1), .req_count(req_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_d1(input logic [15:0] v);
      tb_d1_oe = 1'b1; tb_d1 = v; #1;
   endtask

   task automatic drive_c1(input logic [2:0] v);
      tb_c1_oe = 1'b1; tb_c1 = v; #1;
   endtask

   task automatic release_bus();
      tb_d1_oe = 1'b0; tb_c1_oe = 1'b0; #1;
   endtask

   // Present a request for one cycle; returns in the ADDR1 cycle
   task automatic issue(input logic [2:0] c, input logic [17:0] a, input logic [31:0] w);
      req_valid = 1'b1; req_cmd = c; req_addr = a; req_wdata = w;
      tick();
      req_valid = 1'b0; req_cmd = 3'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b1; req_cmd = 3'd3; req_addr = 18'h2A5C3; req_wdata = 32'h0;
      drive_d1(16'h5A5A);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (C1 !== 3'd0) $display("FAIL rst_c1: got %h want 0", C1); else passes++;
         checks++; if (D1 !== 16'h5A5A) $display("FAIL rst_d1_released: got %h want 5a5a", D1); else passes++;
         checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", req_ready); else passes++;
         checks++; if (req_count !== 32'd0) $display("FAIL rst_count: got %0d want 0", req_count); else passes++;
         checks++; if (A1 !== 14'h0) $display("FAIL rst_a1: got %h want 0", A1); else passes++;
         checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else passes++;
      end
      reset = 1'b0; req_valid = 1'b0;
      tick();
      checks++; if (A1 !== 14'h0) $display("FAIL rst_no_addr1: got %h want 0", A1); else passes++;
      checks++; if (req_ready !== 1'b1) $display("FAIL rst_idle_ready: got %b want 1", req_ready); else passes++;
      req_valid = 1'b1; req_cmd = 3'd0;
      tick(); tick();
      checks++; if (req_ready !== 1'b1) $display("FAIL nop_ready: got %b want 1", req_ready); else passes++;
      checks++; if (req_count !== 32'd0) $display("FAIL nop_count: got %0d want 0", req_count); else passes++;
      checks++; if (C1 !== 3'd0) $display("FAIL nop_c1: got %h want 0", C1); else passes++;
      req_valid = 1'b0;
      release_bus();
   endtask

   task automatic test_read32();
      issue(3'd3, 18'h2A5C3, 32'h0);
      checks++; if (A1 !== 14'h2A5C) $display("FAIL r32_a1_addr1: got %h want 2a5c", A1); else passes++;
      checks++; if (C1 !== 3'd3) $display("FAIL r32_c1_addr1: got %h want 3", C1); else passes++;
      checks++; if (req_ready !== 1'b0) $display("FAIL r32_ready_busy: got %b want 0", req_ready); else passes++;
      checks++; if (req_count !== 32'd1) $display("FAIL r32_count: got %0d want 1", req_count); else passes++;
      tick();
      checks++; if (A1 !== 14'h0003) $display("FAIL r32_a1_addr2: got %h want 0003", A1); else passes++;
      checks++; if (C1 !== 3'd3) $display("FAIL r32_c1_addr2: got %h want 3", C1); else passes++;
      tick();
      drive_c1(3'b010); drive_d1(16'h5A5A);
      checks++; if (C1 !== 3'b010) $display("FAIL r32_turn_c1_released: got %b want 010", C1); else passes++;
      checks++; if (D1 !== 16'h5A5A) $display("FAIL r32_turn_d1_released: got %h want 5a5a", D1); else passes++;
      checks++; if (A1 !== 14'h0003) $display("FAIL r32_turn_a1_hold: got %h want 0003", A1); else passes++;
      tick();
      tick();
      checks++; if (resp_valid !== 1'b0) $display("FAIL r32_gap_no_resp: got %b want 0", resp_valid); else passes++;
      drive_c1(3'b111); drive_d1(16'hBEEF);
      tick();
      checks++; if (resp_valid !== 1'b0) $display("FAIL r32_beat0_no_resp: got %b want 0", resp_valid); else passes++;
      drive_d1(16'hDEAD);
      tick();
      release_bus();
      checks++; if (resp_valid !== 1'b1) $display("FAIL r32_resp_valid: got %b want 1", resp_valid); else passes++;
      checks++; if (resp_rdata !== 32'hDEADBEEF) $display("FAIL r32_rdata: got %h want deadbeef", resp_rdata); else passes++;
      checks++; if (resp_err !== 1'b0) $display("FAIL r32_err: got %b want 0", resp_err); else passes++;
      checks++; if (C1 !== 3'd0) $display("FAIL r32_done_c1_nop: got %h want 0", C1); else passes++;
      tick();
      checks++; if (resp_valid !== 1'b0) $display("FAIL r32_resp_pulse: got %b want 0", resp_valid); else passes++;
      checks++; if (req_ready !== 1'b1) $display("FAIL r32_ready_again: got %b want 1", req_ready); else passes++;
   endtask

   task automatic test_write16();
      issue(3'd6, 18'h00011, 32'h1234ABCD);
      checks++; if (A1 !== 14'h0001) $display("FAIL w16_a1_addr1: got %h want 0001", A1); else passes++;
      checks++; if (C1 !== 3'd6) $display("FAIL w16_c1_addr1: got %h want 6", C1); else passes++;
      checks++; if (D1 !== 16'hABCD) $display("FAIL w16_d1_addr1: got %h want abcd", D1); else passes++;
      checks++; if (req_count !== 32'd2) $display("FAIL w16_count: got %0d want 2", req_count); else passes++;
      tick();
      checks++; if (A1 !== 14'h0001) $display("FAIL w16_a1_addr2: got %h want 0001", A1); else passes++;
      checks++; if (C1 !== 3'd6) $display("FAIL w16_c1_addr2: got %h want 6", C1); else passes++;
      checks++; if (D1 !== 16'hABCD) $display("FAIL w16_d1_addr2: got %h want abcd", D1); else passes++;
      tick();
      drive_d1(16'h5A5A);
      checks++; if (D1 !== 16'h5A5A) $display("FAIL w16_turn_d1_released: got %h want 5a5a", D1); else passes++;
      tick();
      drive_c1(3'b111); drive_d1(16'hFFFF);
      tick();
      release_bus();
      checks++; if (resp_valid !== 1'b1) $display("FAIL w16_resp_valid: got %b want 1", resp_valid); else passes++;
      checks++; if (resp_rdata !== 32'h0) $display("FAIL w16_rdata_zero: got %h want 0", resp_rdata); else passes++;
      tick();
   endtask

   task automatic test_back_to_back();
      issue(3'd1, 18'h3FFFF, 32'h0);
      checks++; if (A1 !== 14'h3FFF) $display("FAIL r8_a1_addr1: got %h want 3fff", A1); else passes++;
      checks++; if (req_count !== 32'd3) $display("FAIL r8_count: got %0d want 3", req_count); else passes++;
      tick();
      checks++; if (A1 !== 14'h000F) $display("FAIL r8_a1_addr2: got %h want 000f", A1); else passes++;
      tick();
      tick();
      drive_c1(3'b111); drive_d1(16'hFF7E);
      tick();
      release_bus();
      checks++; if (resp_valid !== 1'b1) $display("FAIL r8_resp_valid: got %b want 1", resp_valid); else passes++;
      checks++; if (resp_rdata !== 32'h0000007E) $display("FAIL r8_rdata_mask: got %h want 0000007e", resp_rdata); else passes++;
      req_valid = 1'b1; req_cmd = 3'd2; req_addr = 18'h00020; req_wdata = 32'h0;
      tick();
      checks++; if (req_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", req_ready); else passes++;
      checks++; if (resp_valid !== 1'b0) $display("FAIL b2b_resp_pulse: got %b want 0", resp_valid); else passes++;
      tick();
      req_valid = 1'b0; req_cmd = 3'd0;
      checks++; if (A1 !== 14'h0002) $display("FAIL b2b_a1_addr1: got %h want 0002", A1); else passes++;
      checks++; if (C1 !== 3'd2) $display("FAIL b2b_c1_addr1: got %h want 2", C1); else passes++;
      checks++; if (req_count !== 32'd4) $display("FAIL b2b_count: got %0d want 4", req_count); else passes++;
      tick();
      tick();
      tick();
      drive_c1(3'b111); drive_d1(16'h8001);
      tick();
      release_bus();
      checks++; if (resp_valid !== 1'b1) $display("FAIL r16_resp_valid: got %b want 1", resp_valid); else passes++;
      checks++; if (resp_rdata !== 32'h00008001) $display("FAIL r16_rdata: got %h want 00008001", resp_rdata); else passes++;
      tick();
   endtask

   task automatic test_reset_in_wait();
      issue(3'd3, 18'h10000, 32'h0);
      checks++; if (A1 !== 14'h1000) $display("FAIL rw_a1_addr1: got %h want 1000", A1); else passes++;
      tick();
      tick();
      tick();
      drive_c1(3'b111); drive_d1(16'h1111);
      tick();
      reset = 1'b1;
      release_bus();
      tick();
      checks++; if (resp_valid !== 1'b0) $display("FAIL rw_no_resp: got %b want 0", resp_valid); else passes++;
      checks++; if (req_ready !== 1'b1) $display("FAIL rw_idle: got %b want 1", req_ready); else passes++;
      checks++; if (req_count !== 32'd0) $display("FAIL rw_count_cleared: got %0d want 0", req_count); else passes++;
      checks++; if (C1 !== 3'd0) $display("FAIL rw_c1_nop: got %h want 0", C1); else passes++;
      reset = 1'b0;
      drive_d1(16'h2222);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (resp_valid !== 1'b0) $display("FAIL rw_late_beat: got %b want 0", resp_valid); else passes++;
         checks++; if (req_ready !== 1'b1) $display("FAIL rw_stay_idle: got %b want 1", req_ready); else passes++;
      end
      release_bus();
      issue(3'd2, 18'h00005, 32'h0);
      checks++; if (req_count !== 32'd1) $display("FAIL rw_next_count: got %0d want 1", req_count); else passes++;
      tick();
      tick();
      tick();
      drive_c1(3'b111); drive_d1(16'h0042);
      tick();
      release_bus();
      checks++; if (resp_valid !== 1'b1) $display("FAIL rw_next_resp: got %b want 1", resp_valid); else passes++;
      checks++; if (resp_rdata !== 32'h00000042) $display("FAIL rw_next_rdata: got %h want 00000042", resp_rdata); else passes++;
      tick();
   endtask

`ifdef CPU_BUS_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      issue(3'd1, 18'h00100, 32'h0);
      tick();
      tick();
      tick();
      n = 0;
      while (resp_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++; if (n !== 16) $display("FAIL to_wait_cycles: got %0d want 16", n); else passes++;
      checks++; if (resp_err !== 1'b1) $display("FAIL to_err: got %b want 1", resp_err); else passes++;
      checks++; if (resp_rdata !== 32'h0) $display("FAIL to_rdata: got %h want 0", resp_rdata); else passes++;
      tick();
      checks++; if (resp_err !== 1'b0) $display("FAIL to_err_pulse: got %b want 0", resp_err); else passes++;
   endtask
`endif

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_cmd = 3'd0; req_addr = 18'h0; req_wdata = 32'h0;
      tb_d1_oe = 1'b0; tb_d1 = 16'h0; tb_c1_oe = 1'b0; tb_c1 = 3'd0;
      test_reset();
      test_read32();
      test_write16();
      test_back_to_back();
      test_reset_in_wait();
`ifdef CPU_BUS_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
